// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension arbiter: format codes,
// immediate field positions and the output buffer state encoding.
package imm_ext_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        FMT_DADDR9   = 2'd0,
        FMT_ALUIMM12 = 2'd1,
        FMT_CONDBR19 = 2'd2,
        FMT_BR26     = 2'd3
    } imm_fmt_t;

    localparam int DADDR9_LO   = 12;
    localparam int DADDR9_W    = 9;
    localparam int ALUIMM12_LO = 10;
    localparam int ALUIMM12_W  = 12;
    localparam int CONDBR19_LO = 5;
    localparam int CONDBR19_W  = 19;
    localparam int BR26_LO     = 0;
    localparam int BR26_W      = 26;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/imm_field_extend.sv
// Combinational immediate extraction: picks the field for the format code,
// sign- or zero-extends it to XLEN and applies the branch word-offset shift.
module imm_field_extend
    import imm_ext_pkg::*;
#(
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic [31:0]     instr,
    input  logic [1:0]      fmt,
    output logic [XLEN-1:0] imm
);

    logic [XLEN-1:0] br_ext;

    always_comb begin
        imm    = '0;
        br_ext = '0;
        case (imm_fmt_t'(fmt))
            FMT_DADDR9: begin
                imm = {{(XLEN-DADDR9_W){instr[DADDR9_LO+DADDR9_W-1]}},
                       instr[DADDR9_LO +: DADDR9_W]};
            end
            FMT_ALUIMM12: begin
                imm = {{(XLEN-ALUIMM12_W){1'b0}}, instr[ALUIMM12_LO +: ALUIMM12_W]};
            end
            FMT_CONDBR19: begin
                // Shift happens after extension; bits leaving bit 63 are dropped.
                br_ext = {{(XLEN-CONDBR19_W){instr[CONDBR19_LO+CONDBR19_W-1]}},
                          instr[CONDBR19_LO +: CONDBR19_W]};
                imm    = br_ext << BR_SHIFT;
            end
            FMT_BR26: begin
                br_ext = {{(XLEN-BR26_W){instr[BR26_LO+BR26_W-1]}},
                          instr[BR26_LO +: BR26_W]};
                imm    = br_ext << BR_SHIFT;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate-extension datapath between the
// decode stage (port 0) and the branch-target unit (port 1).
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int unsigned BR_SHIFT  = 2,
    parameter int unsigned START_PRI = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_instr,
    input  logic [1:0]  req0_fmt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_instr,
    input  logic [1:0]  req1_fmt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_imm,
    output logic        out_src
);

    localparam logic START_PRI_B = (START_PRI != 0);

    out_state_t      state_q, state_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            src_q, src_d;
    logic            pri_q, pri_d;

    logic            can_accept;
    logic            gnt0, gnt1, any_gnt;
    logic [31:0]     sel_instr;
    logic [1:0]      sel_fmt;
    logic [XLEN-1:0] ext_imm;

    // Handshake: a transfer happens on an edge where valid && ready are both
    // high. Requesters hold valid/instr/fmt until ready; ready is a
    // combinational grant and is never raised for an invalid requester or
    // during reset. The output side completes on out_valid && out_ready.
    always_comb begin
        can_accept = (state_q == OUT_EMPTY) || out_ready;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (!reset && can_accept) begin
            gnt0 = req0_valid && (!req1_valid || (pri_q == 1'b0));
            gnt1 = req1_valid && (!req0_valid || (pri_q == 1'b1));
        end
        any_gnt    = gnt0 || gnt1;
        req0_ready = gnt0;
        req1_ready = gnt1;
        sel_instr  = gnt1 ? req1_instr : req0_instr;
        sel_fmt    = gnt1 ? req1_fmt   : req0_fmt;
    end

    imm_field_extend #(
        .BR_SHIFT(BR_SHIFT)
    ) u_extend (
        .instr(sel_instr),
        .fmt  (sel_fmt),
        .imm  (ext_imm)
    );

    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        src_d   = src_q;
        pri_d   = pri_q;
        if (any_gnt) begin
            imm_d = ext_imm;
            src_d = gnt1;
            pri_d = ~gnt1;
        end
        case (state_q)
            OUT_EMPTY: if (any_gnt) state_d = OUT_FULL;
            OUT_FULL:  if (out_ready && !any_gnt) state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
            imm_q   <= '0;
            src_q   <= 1'b0;
            pri_q   <= START_PRI_B;
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            src_q   <= src_d;
            pri_q   <= pri_d;
        end
    end

    assign out_valid = (state_q == OUT_FULL);
    assign out_imm   = imm_q;
    assign out_src   = src_q;

endmodule

// File: doc/imm_ext_arbiter.md
Name: imm_ext_arbiter

Overview:
- Shares one immediate-extension datapath (sign/zero extension to 64 bits) between two requesters: decode stage (port 0) and branch-target unit (port 1).
- Arbitrates round-robin, extracts the immediate field selected by a format code, extends it and applies the branch word-offset shift.
- Presents the result through a one-entry registered output buffer with a valid/ready handshake.
- Sits between the instruction decode stage and the EX/branch-address datapath.

Parameters:
- BR_SHIFT, 2, left shift applied to branch-format immediates (word-to-byte offset); legal 0..3.
- START_PRI, 0, requester given priority after reset (0 or 1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  decode request valid
- req0_ready  output  1  decode request accepted this cycle
- req0_instr  input  32  instruction word from decode
- req0_fmt  input  2  immediate format code
- req1_valid  input  1  branch-unit request valid
- req1_ready  output  1  branch-unit request accepted this cycle
- req1_instr  input  32  instruction word from branch unit
- req1_fmt  input  2  immediate format code
- out_valid  output  1  result register holds valid data
- out_ready  input  1  consumer accepts result
- out_imm  output  64  extended immediate
- out_src  output  1  requester that produced out_imm

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- Format codes (shared package):
  - 0 = DADDR9: instr[20:12], sign-extended.
  - 1 = ALUIMM12: instr[21:10], zero-extended.
  - 2 = CONDBR19: instr[23:5], sign-extended, then << BR_SHIFT.
  - 3 = BR26: instr[25:0], sign-extended, then << BR_SHIFT.
- Shift and width rules:
  - The shift is applied after extension on the 64-bit value; bits shifted out at bit 63 are discarded.
  - Sign bit is the top bit of the extracted field.
- Acceptance: can_accept = !out_valid || out_ready. A grant happens only when can_accept is high.
- Arbitration:
  - 1-bit priority pointer `pri`.
  - If exactly one request is valid, that requester is granted.
  - If both are valid, requester `pri` is granted.
  - After any grant, `pri` becomes the other requester, so a losing requester wins the next contention.
  - `pri` changes only on a grant.
- Handshake:
  - reqN_ready is combinational. It is high only in the cycle requester N is granted.
  - A requester must hold valid, instr and fmt stable until ready.
  - The block never asserts ready to an invalid requester.
- Latency:
  - A grant in cycle T loads the output register at edge T+1: out_valid=1, out_imm, out_src.
  - Result latency is 1 cycle.
- Throughput: with out_ready held high, one result per cycle, including back-to-back grants.
- Output buffer:
  - out_valid clears at the edge where out_valid && out_ready && no new grant.
  - If the buffer is consumed and a new grant happens in the same cycle, the register reloads and out_valid stays 1.
  - While out_valid && !out_ready: both ready outputs are 0, out_imm and out_src are held stable, and `pri` is unchanged.
- Output state machine:
  - EMPTY: out_valid=0. Moves to FULL on a grant.
  - FULL: out_valid=1.
    - Stays FULL on stall, or on consume with a simultaneous grant.
    - Moves to EMPTY on consume with no grant.
- Reset values:
  - out_valid=0, out_imm=0, out_src=0, pri=START_PRI.
  - req0_ready and req1_ready are 0 while reset is high.
- Reset mid-operation: any buffered result is discarded with no handshake to the consumer. Requests presented during reset are not accepted.
- Illegal input: none possible; all 2-bit fmt values are defined.

Decomposition:
- Package imm_ext_pkg:
  - Enum imm_fmt_t for the four codes.
  - Field position and width constants: DADDR9 lo=12/w=9, ALUIMM12 lo=10/w=12, CONDBR19 lo=5/w=19, BR26 lo=0/w=26.
  - XLEN=64.
- Sub-module imm_field_extend: purely combinational; inputs instr and fmt, output 64-bit immediate; instantiated once and fed by the granted requester's mux.
- The arbiter, handshake and output register stay in imm_ext_arbiter.

Test Plan:
- Format coverage, req0 only, out_ready=1:
  - fmt=0 with instr[20:12]=9'h100 -> out_imm=64'hFFFF_FFFF_FFFF_FF00 one cycle later, out_src=0.
  - fmt=1 with instr[21:10]=12'hFFF -> out_imm=64'h0000_0000_0000_0FFF.
- Branch shift, req1 only:
  - fmt=3 with instr[25:0]=26'h3FFFFFF -> out_imm=64'hFFFF_FFFF_FFFF_FFFC (BR_SHIFT=2).
  - fmt=2 with instr[23:5]=19'h0_0001 -> out_imm=64'h4.
- Contention: both valid continuously from reset with START_PRI=0, out_ready=1 -> grants alternate 0,1,0,1; out_src sequence 0,1,0,1 on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles while both requesters are valid -> both ready=0, out_imm stable, pri frozen; on release, the requester opposite to the last grant wins.
- Reset mid-operation: assert reset while out_valid=1 and out_ready=0 -> next edge out_valid=0, out_imm=0, pri=START_PRI, no ready pulses during reset.
